sdc: RTL
========

# sdc

Saturating down-counter: the draining end of the saturating up-counter. It loads a count, decrements one step per `dec` request, and holds at zero. A one-cycle `done` pulse marks the step from 1 to 0. A sticky `err` flags an illegal load value or a decrement attempted while empty. It sits beside the up-counter so a producer can fill a count and a consumer can drain it.

## Interface
- `WIDTH`, default 3: counter width in bits.
- `MAX`, default 5: largest legal load value. Must satisfy `MAX <= 2**WIDTH-1`.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous reset, active-low: asserting `rst`=0 resets immediately, independent of `clk`.
- `ctr_rst`  in  1  synchronous active-high clear.
- `ld`  in  1  load request.
- `ld_val`  in  WIDTH  value to load.
- `dec`  in  1  decrement request.
- `out`  out  WIDTH  current count (registered).
- `zero`  out  1  `out == 0`, combinational decode of the register.
- `done`  out  1  registered one-cycle pulse on the 1→0 step.
- `err`  out  1  registered sticky error.

## Operation
- States: IDLE (never loaded or cleared), RUN (`out > 0`), EMPTY (drained or loaded with 0).
- Per-edge priority: `ctr_rst` first, then `ld`, then `dec`.
- `ctr_rst`=1:
  - `out`←0, state←IDLE, `err`←0, `done`←0.
  - `ld` and `dec` in that cycle are ignored.
- `ld`=1, legal `ld_val <= MAX`:
  - `out`←`ld_val`.
  - State←RUN if `ld_val != 0`, else EMPTY.
  - `done`←0.
  - `dec` in the same cycle is ignored.
- `ld`=1, illegal `ld_val > MAX`:
  - `out` and state unchanged.
  - `err`←1.
  - `dec` in the same cycle is ignored.
- `dec` in IDLE: ignored; no error.
- `dec` in RUN:
  - `out`←`out-1`.
  - If `out` was 1: state←EMPTY and `done`←1 for exactly the next cycle.
- `dec` in EMPTY: `out` stays 0 (saturates, never wraps to 2**WIDTH-1) and `err`←1.
- `err` is sticky. Only `ctr_rst` or `rst` clears it. A legal load does not clear it.
- `done` is high only in the cycle after the 1→0 step, otherwise 0.
- Subtraction is WIDTH-bit. Wrap is impossible by construction; the bench asserts `out <= MAX` at all times.

## Timing
- Reset values under `rst`=0:
  - `out`=0, state=IDLE, `err`=0, `done`=0.
  - `zero`=1, since it is the combinational decode of `out`.
- Release of `rst` has no effect until the next rising edge.
- Latency:
  - Load visible on `out` one cycle after the `ld` edge.
  - Each decrement visible one cycle after its edge.
  - `done` is aligned with `out` becoming 0.
- `dec` held high from a load of N reaches 0 after N edges. On edge N+1 it raises `err`.
- Throughput: one operation per cycle. No handshake stall; the block never back-pressures.
- Asserting `rst` mid-drain aborts immediately. No `done` is emitted.

## Structure
- Shared package `sdc_pkg` holds:
  - state encodings `SDC_IDLE`=2'b00, `SDC_RUN`=2'b01, `SDC_EMPTY`=2'b10;
  - default `WIDTH`/`MAX` constants shared with the up-counter.
- One sub-module, `dffr_n`: 1-bit flop with asynchronous active-low reset to 0.
  - Instantiated for every state, `out`, `err` and `done` bit.
  - The existing synchronous `dff` cell is not used here.
- Next-state and next-count logic is a single combinational block in `sdc`, following the priority order above.

## Test plan
- Reset then load: `rst`=0 → `out`=0, `zero`=1, `err`=0, `done`=0. Release `rst`, `ld`=1 with `ld_val`=5 → next cycle `out`=5, `zero`=0.
- Full drain: load 3, hold `dec`=1 → `out` goes 2, 1, 0. `done`=1 only in the cycle `out`=0. The next `dec` keeps `out`=0 and sets `err`=1.
- Illegal load: load 2, then `ld`=1 with `ld_val`=6 → `out` stays 2, `err`=1. A later legal load of 4 gives `out`=4 with `err` still 1. `ctr_rst`=1 → `out`=0, `err`=0.
- Simultaneous events, three cases:
  - `ld`=1 (`ld_val`=4) with `dec`=1 → `out`=4.
  - `ctr_rst`=1 with `ld`=1 → `out`=0, state IDLE.
  - `dec` in IDLE → `out`=0, `err`=0.
- Reset mid-operation: load 5, decrement twice, assert `rst`=0 between edges → `out`=0 immediately. After release no `done` pulse, and `dec` is ignored (IDLE).

Source files
------------

// File: rtl/sdc_pkg.sv
// Shared definitions for the saturating counter pair: state encodings and
// default geometry used by both the up-counter and the down-counter.
package sdc_pkg;

   typedef enum logic [1:0] {
      SDC_IDLE  = 2'b00,
      SDC_RUN   = 2'b01,
      SDC_EMPTY = 2'b10
   } sdc_state_e;

   localparam int unsigned SdcWidth = 3;
   localparam int unsigned SdcMax   = 5;

endpackage

// File: rtl/dffr_n.sv
// Single-bit flop with asynchronous active-low reset to 0.
module dffr_n (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o
);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         q_o <= 1'b0;
      end else begin
         q_o <= d_i;
      end
   end

endmodule

// File: rtl/sdc.sv
// Saturating down-counter: loads a count, drains one step per dec, holds at
// zero, pulses done on the 1->0 step and keeps a sticky err flag.
module sdc
   import sdc_pkg::*;
#(
   parameter int unsigned WIDTH = SdcWidth,
   parameter int unsigned MAX   = SdcMax
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             ctr_rst_i,
   input  logic             ld_i,
   input  logic [WIDTH-1:0] ld_val_i,
   input  logic             dec_i,
   output logic [WIDTH-1:0] out_o,
   output logic             zero_o,
   output logic             done_o,
   output logic             err_o
);

   localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MAX);
   localparam logic [WIDTH-1:0] One    = WIDTH'(1);
   localparam int unsigned      NBits  = 2 + WIDTH + 2;

   sdc_state_e       state_q, state_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic             err_q, err_d;
   logic             done_q, done_d;

   logic [NBits-1:0] bits_d, bits_q;

   always_comb begin
      state_d = state_q;
      out_d   = out_q;
      err_d   = err_q;
      done_d  = 1'b0;
      if (ctr_rst_i) begin
         state_d = SDC_IDLE;
         out_d   = '0;
         err_d   = 1'b0;
      end else if (ld_i) begin
         if (ld_val_i <= MaxVal) begin
            out_d   = ld_val_i;
            state_d = (ld_val_i != '0) ? SDC_RUN : SDC_EMPTY;
         end else begin
            err_d = 1'b1;
         end
      end else if (dec_i) begin
         unique case (state_q)
            SDC_RUN: begin
               out_d = out_q - One;
               if (out_q == One) begin
                  state_d = SDC_EMPTY;
                  done_d  = 1'b1;
               end
            end
            // Saturate instead of wrapping; draining an empty counter is an error.
            SDC_EMPTY: err_d = 1'b1;
            default: ;
         endcase
      end
   end

   assign bits_d = {state_d, out_d, err_d, done_d};

   for (genvar i = 0; i < NBits; i++) begin : g_bit
      dffr_n u_bit (
         .clk_i  (clk_i),
         .rst_ni (rst_ni),
         .d_i    (bits_d[i]),
         .q_o    (bits_q[i])
      );
   end

   assign state_q = sdc_state_e'(bits_q[NBits-1 -: 2]);
   assign out_q   = bits_q[WIDTH+1 -: WIDTH];
   assign err_q   = bits_q[1];
   assign done_q  = bits_q[0];

   assign out_o  = out_q;
   assign zero_o = (out_q == '0);
   assign done_o = done_q;
   assign err_o  = err_q;

endmodule
